// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the FIFO-backed UART receiver.
// FSM state encoding and the layout of one queued receive entry.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2,
    ST_BREAK
  } rx_state_t;

  localparam int ENTRY_W    = 10;
  localparam int RATE_W_DEF = 19;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_buf.sv
// First-word-fall-through FIFO; the head entry is visible combinationally.
// Pointers wrap naturally because DEPTH is a power of two.
module uart_rx_fifo_buf #(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive engine feeding a FWFT FIFO with per-byte error flags.
// Break detection is built only when UART_RX_BREAK_DET_EN is defined.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int RATE_W = RATE_W_DEF,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx,
  input  logic              i_read,
  input  logic              i_eight,
  input  logic              i_pen,
  input  logic              i_ohel,
  input  logic              i_two_stop,
  input  logic [RATE_W-1:0] i_rate,
  output logic              o_rxrdy,
  output logic [7:0]        o_rx_dout,
  output logic              o_perr,
  output logic              o_ferr,
  output logic              o_ovf,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_break
);

`ifdef UART_RX_BREAK_DET_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif

  localparam int FCW = $clog2(DEPTH) + 1;

  logic              rx_meta;
  logic              rxs;
  logic              rxs_d;
  rx_state_t         state;
  logic [RATE_W-1:0] cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        data;
  logic              perr;
  logic              ferr;
  logic              zeros;
  logic              brk;
  logic              tick;
  logic              last_bit;
  logic              push;
  logic              is_break;
  logic              stop_ferr;
  rx_entry_t         wr_ent;
  rx_entry_t         head;
  logic [ENTRY_W-1:0] head_raw;
  logic              full;
  logic              empty;
  logic [FCW-1:0]    fcount;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign tick      = (cnt == '0);
  assign last_bit  = (bit_idx == {2'b11, i_eight});
  assign stop_ferr = !rxs || (state == ST_STOP2 && ferr);

  // Push happens on the final stop-sample edge, not a cycle later.
  always_comb begin
    push     = 1'b0;
    is_break = 1'b0;
    if (tick) begin
      case (state)
        ST_STOP1: begin
          is_break = BRK_EN && zeros && !rxs;
          push     = !i_two_stop || is_break;
        end
        ST_STOP2: push = 1'b1;
        default:  push = 1'b0;
      endcase
    end
  end

  assign wr_ent = '{ferr: stop_ferr,
                    perr: perr && !is_break,
                    data: data};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      data    <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      zeros   <= 1'b1;
      brk     <= 1'b0;
    end else begin
      brk <= 1'b0;
      if (state != ST_IDLE && state != ST_BREAK)
        cnt <= tick ? i_rate - RATE_W'(1) : cnt - RATE_W'(1);
      case (state)
        ST_IDLE: begin
          if (rxs_d && !rxs) begin
            cnt     <= i_rate >> 1;
            bit_idx <= '0;
            data    <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            zeros   <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (tick) state <= rxs ? ST_IDLE : ST_DATA;
        end
        ST_DATA: begin
          if (tick) begin
            data[bit_idx] <= rxs;
            zeros         <= zeros && !rxs;
            bit_idx       <= bit_idx + 3'd1;
            if (last_bit)
              state <= i_pen ? ST_PARITY : ST_STOP1;
          end
        end
        ST_PARITY: begin
          if (tick) begin
            perr  <= rxs ^ (^data) ^ i_ohel;
            zeros <= zeros && !rxs;
            state <= ST_STOP1;
          end
        end
        ST_STOP1: begin
          if (tick) begin
            ferr <= !rxs;
            if (is_break) begin
              brk   <= 1'b1;
              state <= ST_BREAK;
            end else begin
              state <= i_two_stop ? ST_STOP2 : ST_IDLE;
            end
          end
        end
        ST_STOP2: begin
          if (tick) state <= ST_IDLE;
        end
        ST_BREAK: begin
          if (rxs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_rx_fifo_buf #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_buf (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .pop   (i_read),
    .din   (wr_ent),
    .dout  (head_raw),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );

  // Set wins over the clear from an accepted read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_ovf <= 1'b0;
    else if (push && full && !i_read)
      o_ovf <= 1'b1;
    else if (i_read && !empty)
      o_ovf <= 1'b0;
  end

  assign head      = rx_entry_t'(head_raw);
  assign o_rxrdy   = !empty;
  assign o_rx_dout = empty ? 8'h00 : head.data;
  assign o_perr    = !empty && head.perr;
  assign o_ferr    = !empty && head.ferr;
  assign o_count   = CNT_W'(fcount);
  assign o_break   = BRK_EN && brk;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: framing table plus FIFO,
// overflow, glitch, reset and line-break sequences.
module tb_uart_rx_fifo;

  localparam int RATE  = 109;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef UART_RX_BREAK_DET_EN
  localparam int EXP_BRK = 1;
`else
  localparam int EXP_BRK = 0;
`endif

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_rx = 1'b1;
  logic             i_read = 1'b0;
  logic             i_eight = 1'b1;
  logic             i_pen = 1'b0;
  logic             i_ohel = 1'b0;
  logic             i_two_stop = 1'b0;
  logic [18:0]      i_rate = 19'(RATE);
  logic             o_rxrdy;
  logic [7:0]       o_rx_dout;
  logic             o_perr;
  logic             o_ferr;
  logic             o_ovf;
  logic [CNT_W-1:0] o_count;
  logic             o_break;

  int n_checks = 0;
  int n_fail   = 0;
  int brk_cnt  = 0;
  logic [9:0] q[$];

  typedef struct {
    logic [7:0] d;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic       two;
    logic       par;
    logic       s1;
    logic       s2;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[9];

  uart_rx_fifo #(.RATE_W(19), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rx       (i_rx),
    .i_read     (i_read),
    .i_eight    (i_eight),
    .i_pen      (i_pen),
    .i_ohel     (i_ohel),
    .i_two_stop (i_two_stop),
    .i_rate     (i_rate),
    .o_rxrdy    (o_rxrdy),
    .o_rx_dout  (o_rx_dout),
    .o_perr     (o_perr),
    .o_ferr     (o_ferr),
    .o_ovf      (o_ovf),
    .o_count    (o_count),
    .o_break    (o_break)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_break) brk_cnt <= brk_cnt + 1;
  end

  function automatic vec_t mk(input logic [7:0] d, input logic eight,
                              input logic pen, input logic ohel,
                              input logic two, input logic par,
                              input logic s1, input logic s2,
                              input logic [9:0] exp);
    vec_t v;
    v.d = d; v.eight = eight; v.pen = pen; v.ohel = ohel;
    v.two = two; v.par = par; v.s1 = s1; v.s2 = s2; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    repeat (RATE) @(posedge i_clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic eight,
                            input logic pen, input logic par,
                            input logic s1, input logic s2,
                            input logic two);
    send_bit(1'b0);
    for (int i = 0; i < (eight ? 8 : 7); i++) send_bit(d[i]);
    if (pen) send_bit(par);
    send_bit(s1);
    if (two) send_bit(s2);
    send_bit(1'b1);
    send_bit(1'b1);
  endtask

  task automatic send_8n1(input logic [7:0] d);
    i_eight = 1'b1; i_pen = 1'b0; i_two_stop = 1'b0;
    send_frame(d, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic read_check(input string name);
    logic [9:0] e;
    if (q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check({name, "_rdy"}, 32'(o_rxrdy), 32'd1);
      check(name, {22'd0, o_ferr, o_perr, o_rx_dout}, {22'd0, e});
    end
    i_read = 1'b1;
    @(posedge i_clk); #1;
    i_read = 1'b0;
  endtask

  initial begin
    int b0;
    vecs[0] = mk(8'hA5, 1, 0, 0, 0, 0, 1, 1, {2'b00, 8'hA5});
    vecs[1] = mk(8'h41, 0, 1, 0, 0, 1, 1, 1, {2'b01, 8'h41});
    vecs[2] = mk(8'h41, 0, 1, 0, 0, 0, 1, 1, {2'b00, 8'h41});
    vecs[3] = mk(8'h3C, 1, 1, 1, 0, 1, 1, 1, {2'b00, 8'h3C});
    vecs[4] = mk(8'h3C, 1, 1, 1, 0, 0, 1, 1, {2'b01, 8'h3C});
    vecs[5] = mk(8'h5A, 1, 0, 0, 1, 0, 1, 0, {2'b10, 8'h5A});
    vecs[6] = mk(8'h81, 1, 0, 0, 1, 0, 1, 1, {2'b00, 8'h81});
    vecs[7] = mk(8'hFF, 0, 0, 0, 0, 0, 0, 1, {2'b10, 8'h7F});
    vecs[8] = mk(8'h96, 0, 1, 0, 0, 1, 1, 1, {2'b00, 8'h16});

    repeat (3) @(posedge i_clk); #1;
    check("rst_rxrdy", 32'(o_rxrdy), 0);
    check("rst_count", 32'(o_count), 0);
    check("rst_dout",  32'(o_rx_dout), 0);
    check("rst_flags", {28'd0, o_perr, o_ferr, o_ovf, o_break}, 0);
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk); #1;

    for (int i = 0; i < 9; i++) begin
      i_eight = vecs[i].eight; i_pen = vecs[i].pen;
      i_ohel = vecs[i].ohel; i_two_stop = vecs[i].two;
      q.push_back(vecs[i].exp);
      send_frame(vecs[i].d, vecs[i].eight, vecs[i].pen, vecs[i].par,
                 vecs[i].s1, vecs[i].s2, vecs[i].two);
      check($sformatf("vec%0d_count", i), 32'(o_count), 1);
      read_check($sformatf("vec%0d_head", i));
      check($sformatf("vec%0d_rdy_after", i), 32'(o_rxrdy), 0);
    end

    i_eight = 1'b1; i_pen = 1'b0; i_two_stop = 1'b0;
    i_rx = 1'b0;
    repeat (3) @(posedge i_clk); #1;
    i_rx = 1'b1;
    repeat (3 * RATE) @(posedge i_clk); #1;
    check("glitch_count", 32'(o_count), 0);

    for (int i = 0; i < 17; i++) begin
      if (i < DEPTH) q.push_back({2'b00, 8'(i + 8'h10)});
      send_8n1(8'(i + 8'h10));
    end
    check("ovf_count", 32'(o_count), DEPTH);
    check("ovf_flag", 32'(o_ovf), 1);
    read_check("ovf_head");
    check("ovf_clr", 32'(o_ovf), 0);
    check("ovf_count_after", 32'(o_count), DEPTH - 1);
    for (int i = 1; i < DEPTH; i++) read_check($sformatf("drain%0d", i));
    check("drain_count", 32'(o_count), 0);

    i_read = 1'b1;
    @(posedge i_clk); #1;
    i_read = 1'b0;
    check("empty_read_count", 32'(o_count), 0);
    check("empty_read_flags", {29'd0, o_rxrdy, o_ovf, o_ferr}, 0);

    for (int i = 0; i < 3; i++) send_8n1(8'(8'hE0 + i));
    check("pre_rst_count", 32'(o_count), 3);
    i_rx = 1'b0;
    repeat (3 * RATE) @(posedge i_clk); #1;
    i_rst_n = 1'b0;
    i_rx = 1'b1;
    repeat (2) @(posedge i_clk); #1;
    check("mid_rst_rdy", 32'(o_rxrdy), 0);
    check("mid_rst_count", 32'(o_count), 0);
    check("mid_rst_out", {22'd0, o_ferr, o_perr, o_rx_dout}, 0);
    check("mid_rst_flags", {30'd0, o_ovf, o_break}, 0);
    i_rst_n = 1'b1;
    repeat (3) @(posedge i_clk); #1;
    q.delete();
    q.push_back({2'b00, 8'hC3});
    send_8n1(8'hC3);
    check("post_rst_count", 32'(o_count), 1);
    read_check("post_rst_head");

    b0 = brk_cnt;
    i_rx = 1'b0;
    repeat (20 * RATE) @(posedge i_clk); #1;
    i_rx = 1'b1;
    repeat (2 * RATE) @(posedge i_clk); #1;
    check("brk_count", 32'(o_count), 1);
    check("brk_pulses", 32'(brk_cnt - b0), EXP_BRK);
    q.push_back({2'b10, 8'h00});
    read_check("brk_head");
    q.push_back({2'b00, 8'h96});
    send_8n1(8'h96);
    check("post_brk_count", 32'(o_count), 1);
    read_check("post_brk_head");
    check("final_count", 32'(o_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
